muldiv_iter: RTL
================

Name: muldiv_iter

Overview:
Parametrised, multi-cycle RV32M/RV64M-style multiply/divide unit for the EX stage. It replaces the fixed-latency, vendor-IP-based muldiv path with an iterative shift-add multiplier and restoring divider over XLEN bits. It uses valid/ready handshakes on both sides so the pipeline can stall on it. One operation is in flight at a time; the result is held until consumed.

Parameters:
XLEN, 32, operand/result width in bits (legal: 8..64, even).
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request (high only in IDLE)
a  in  XLEN  rs1 operand (dividend / multiplicand)
b  in  XLEN  rs2 operand (divisor / multiplier)
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
flush  in  1  cancel in-flight operation (branch/jump kill)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
r  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out_valid=0, r=0, busy=0, counter=0. rst has priority over flush and all handshakes.
- Accept: in_valid & in_ready at an edge. This latches funct3 and the operand signs, takes the magnitudes |a| and |b| per op signedness, and goes to CALC with count=0.
  - MULH, DIV and REM treat a and b as signed.
  - MULHSU treats only a as signed.
  - The unsigned ops take no magnitude.
- FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
- CALC (one bit per cycle, XLEN cycles):
  - Multiply: 2*XLEN-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring. Shift {rem, quo} left by 1, trial subtract the divisor, and set the quotient bit if there is no borrow.
- FIX (1 cycle): sign correction.
  - Product is negated if sign_a ^ sign_b (MULH), or if sign_a (MULHSU).
  - Quotient is negated if sign_a ^ sign_b (DIV).
  - Remainder takes the sign of the dividend (REM).
  - Result selection: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
- DONE: out_valid=1 and r is stable. Exit to IDLE on the edge where out_valid & out_ready. in_ready stays 0 until back in IDLE (no accept in the same cycle as the result drains).
- Normal latency: out_valid rises XLEN+2 edges after the accept edge.
- Special cases: decided at accept, skip CALC/FIX, and go directly to DONE (out_valid one edge after accept).
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = 1<<(XLEN-1), b = all-ones, DIV/REM): DIV gives a; REM gives 0.
- flush=1 at an edge (rst=0): state -> IDLE, out_valid -> 0, and the result is discarded. A flush coinciding with an accept edge drops that request too.
- Inputs a, b and funct3 are sampled only at the accept edge; later changes have no effect.
- Results are bit-exact to the RISC-V M-extension definition for width XLEN.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined:
  - Multiply: CALC terminates at the first edge where the remaining unshifted multiplier magnitude is zero; the accumulator is aligned by the remaining shift count in FIX. Minimum latency is 3 edges; multiply by 0 goes to DONE in 1 edge.
  - Divide: CALC skips leading-zero dividend bits (count preloaded with the dividend's leading-zero count).
- Undefined: fixed XLEN+2 latency for all non-special ops. Results are identical in both builds.

Test Plan:
- XLEN=32, MULH a=0x80000000 b=0x80000000 -> r=0x40000000, out_valid exactly 34 edges after accept (macro off).
- MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> r=0xFFFFFFFF. MUL same operands -> r=0x00000001.
- DIV a=7 b=0xFFFFFFFE -> r=0xFFFFFFFD. REM same operands -> r=0x00000001. DIVU a=100 b=7 -> r=14. REMU -> r=2.
- DIVU a=5 b=0 -> r=0xFFFFFFFF. REM a=5 b=0 -> r=5. DIV a=0x80000000 b=0xFFFFFFFF -> r=0x80000000, REM -> r=0. All with out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> r and out_valid stable, in_ready=0. Raise out_ready -> IDLE next edge and in_ready=1.
- flush at CALC cycle 5 -> IDLE next edge, out_valid never asserted. A new MUL 3*4 then returns r=12. rst mid-CALC -> all outputs 0 next edge.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV M-extension multiply/divide unit with valid/ready on both sides.
// Optional macro MULDIV_EARLY_OUT_EN enables early termination of CALC.
module muldiv_iter #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [2*XLEN-1:0] acc, prod, prod_s;
  logic [XLEN-1:0] opb, m, ma, mb, q, rm, fix_r, spec_r;
  logic [CNT_W-1:0] cnt, lz, sh;
  logic [XLEN:0] add, sub;
  logic [2:0] op;
  logic sign_a, sign_b, sa, sb, is_div, div0, ovf, spec, last;
`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [CNT_W-1:0] lzc(input logic [XLEN-1:0] v);
    lzc = CNT_W'(XLEN - 1);
    for (int i = 0; i < XLEN; i++) if (v[i]) lzc = CNT_W'(XLEN - 1 - i);
  endfunction
`endif
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    is_div = funct3[2];
    sa = a[XLEN-1] & (funct3 == 3'b001 | funct3 == 3'b010 | funct3 == 3'b100 | funct3 == 3'b110);
    sb = b[XLEN-1] & (funct3 == 3'b001 | funct3 == 3'b100 | funct3 == 3'b110);
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    div0 = is_div & (b == '0);
    ovf = is_div & ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    spec_r = ~is_div ? '0 : div0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
`ifdef MULDIV_EARLY_OUT_EN
    spec = div0 | ovf | (~is_div & (b == '0));
    lz = is_div ? lzc(ma) : '0;
    last = (cnt == CNT_W'(XLEN - 1)) | (~op[2] & (m[XLEN-1:1] == '0));
`else
    spec = div0 | ovf;
    lz = '0;
    last = cnt == CNT_W'(XLEN - 1);
`endif
    add = {1'b0, acc[2*XLEN-1:XLEN]} + (m[0] ? {1'b0, opb} : '0);
    sub = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
    // a multiply that stopped early still has XLEN-cnt shifts owed
    sh = CNT_W'(XLEN) - cnt;
    prod = acc >> sh;
    prod_s = (sign_a ^ sign_b) ? -prod : prod;
    q = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rm = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_r = op[2] ? (op[1] ? rm : q) : (op[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = spec ? DONE : CALC;
      CALC: if (last) state_n = FIX;
      FIX: state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      opb <= '0;
      m <= '0;
      cnt <= '0;
      op <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      r <= '0;
    end else if (state == IDLE && in_valid) begin
      op <= funct3;
      sign_a <= sa;
      sign_b <= sb;
      cnt <= lz;
      opb <= is_div ? mb : ma;
      m <= mb;
      acc <= is_div ? {{XLEN{1'b0}}, ma << lz} : '0;
      if (spec) r <= spec_r;
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (op[2]) acc <= sub[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {sub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else begin
        acc <= {add, acc[XLEN-1:1]};
        m <= m >> 1;
      end
    end else if (state == FIX) r <= fix_r;
  end
endmodule
